// File: rtl/ysyx_24100006_icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
// Optional feature macro used by the top: ICACHE_PERF_EN (hit/miss counters).
package ysyx_24100006_icache_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_REFILL_AR,
        S_REFILL_R,
        S_RESP,
        S_FLUSH
    } state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] RESP_OKAY      = 2'b00;
    localparam logic [1:0] RESP_SLVERR    = 2'b10;

    function automatic int word_idx_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int set_idx_w(input int nsets);
        return $clog2(nsets);
    endfunction

endpackage

// File: rtl/ysyx_24100006_icache_meta.sv
// Tag + valid store: registered read port, write port, single-cycle clear of all valid bits.
module ysyx_24100006_icache_meta #(
    parameter int NSETS = 16,
    parameter int TAG_W = 24
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear_all,
    input  logic                     rd_en,
    input  logic [$clog2(NSETS)-1:0] rd_set,
    output logic                     rd_valid,
    output logic [TAG_W-1:0]         rd_tag,
    input  logic                     wr_en,
    input  logic [$clog2(NSETS)-1:0] wr_set,
    input  logic [TAG_W-1:0]         wr_tag,
    input  logic                     wr_valid
);

    logic [NSETS-1:0] valid_q, valid_d;
    logic             rd_valid_q;
    logic [TAG_W-1:0] rd_tag_q;
    logic [TAG_W-1:0] tag_mem [NSETS];

    always_comb begin
        valid_d = valid_q;
        if (clear_all) begin
            valid_d = '0;
        end else if (wr_en) begin
            valid_d[wr_set] = wr_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (rd_en) begin
                rd_valid_q <= valid_q[rd_set];
            end
        end
    end

    // Tags carry no reset; a tag is only trusted when its valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_set] <= wr_tag;
        end
        if (rd_en) begin
            rd_tag_q <= tag_mem[rd_set];
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_tag   = rd_tag_q;

endmodule

// File: rtl/ysyx_24100006_icache.sv
// Direct-mapped I-cache: AXI-Lite word fetch slave, AXI4 INCR line refill master, fence.i flush.
// Define ICACHE_PERF_EN to add the perf_hit/perf_miss counter ports.
module ysyx_24100006_icache
    import ysyx_24100006_icache_pkg::*;
#(
    parameter int NSETS      = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush_req,
    output logic        flush_done,
    input  logic [31:0] s_araddr,
    input  logic        s_arvalid,
    output logic        s_arready,
    output logic        s_rvalid,
    input  logic        s_rready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic [31:0] m_araddr,
    output logic [7:0]  m_arlen,
    output logic [2:0]  m_arsize,
    output logic [1:0]  m_arburst,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic        m_rvalid,
    output logic        m_rready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rlast
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] perf_hit,
    output logic [31:0] perf_miss
`endif
);

    localparam int WORD_W = word_idx_w(LINE_WORDS);
    localparam int SET_W  = set_idx_w(NSETS);
    localparam int IDX_W  = SET_W + WORD_W;
    localparam int TAG_W  = 30 - IDX_W;

    state_e             state_q, state_d;
    logic [29:0]        addr_q, addr_d;      // word address of the current fetch
    logic [31:0]        rdata_q, rdata_d;
    logic [1:0]         rresp_q, rresp_d;
    logic [WORD_W-1:0]  beat_q, beat_d;
    logic               err_q, err_d;
    logic               flush_pend_q, flush_pend_d;
    logic               flush_req_q;

    logic               flush_rise;
    logic               rd_en;
    logic               data_wr;
    logic               meta_wr;
    logic               meta_wr_valid;
    logic               clear_all;
    logic               meta_rd_valid;
    logic [TAG_W-1:0]   meta_rd_tag;
    logic               lookup_hit;
    logic [31:0]        data_rd_q;
    logic [31:0]        data_mem [NSETS*LINE_WORDS];
    logic               unused_addr_bits;

    wire [WORD_W-1:0] word_idx = addr_q[WORD_W-1:0];
    wire [SET_W-1:0]  set_idx  = addr_q[IDX_W-1:WORD_W];
    wire [TAG_W-1:0]  tag      = addr_q[29:IDX_W];

    assign unused_addr_bits = ^s_araddr[1:0];
    assign flush_rise       = flush_req & ~flush_req_q;
    assign lookup_hit       = meta_rd_valid && (meta_rd_tag == tag);

    ysyx_24100006_icache_meta #(
        .NSETS (NSETS),
        .TAG_W (TAG_W)
    ) u_meta (
        .clk       (clk),
        .reset     (reset),
        .clear_all (clear_all),
        .rd_en     (rd_en),
        .rd_set    (s_araddr[IDX_W+1:WORD_W+2]),
        .rd_valid  (meta_rd_valid),
        .rd_tag    (meta_rd_tag),
        .wr_en     (meta_wr),
        .wr_set    (set_idx),
        .wr_tag    (tag),
        .wr_valid  (meta_wr_valid)
    );

    // Arrays are read at the address handshake so the result is ready in LOOKUP.
    always_ff @(posedge clk) begin
        if (data_wr) begin
            data_mem[{set_idx, beat_q}] <= m_rdata;
        end
        if (rd_en) begin
            data_rd_q <= data_mem[s_araddr[IDX_W+1:2]];
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        rdata_d       = rdata_q;
        rresp_d       = rresp_q;
        beat_d        = beat_q;
        err_d         = err_q;
        flush_pend_d  = flush_pend_q | flush_rise;
        s_arready     = 1'b0;
        s_rvalid      = 1'b0;
        m_arvalid     = 1'b0;
        m_rready      = 1'b0;
        flush_done    = 1'b0;
        rd_en         = 1'b0;
        data_wr       = 1'b0;
        meta_wr       = 1'b0;
        meta_wr_valid = 1'b0;
        clear_all     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (flush_pend_q || flush_rise) begin
                    flush_pend_d = 1'b0;
                    state_d      = S_FLUSH;
                end else begin
                    s_arready = 1'b1;
                    if (s_arvalid) begin
                        rd_en   = 1'b1;
                        addr_d  = s_araddr[31:2];
                        state_d = S_LOOKUP;
                    end
                end
            end
            S_LOOKUP: begin
                if (lookup_hit) begin
                    rdata_d = data_rd_q;
                    rresp_d = RESP_OKAY;
                    state_d = S_RESP;
                end else begin
                    beat_d  = '0;
                    err_d   = 1'b0;
                    state_d = S_REFILL_AR;
                end
            end
            S_REFILL_AR: begin
                m_arvalid = 1'b1;
                if (m_arready) begin
                    state_d = S_REFILL_R;
                end
            end
            S_REFILL_R: begin
                m_rready = 1'b1;
                if (m_rvalid) begin
                    data_wr = 1'b1;
                    beat_d  = beat_q + 1'b1;
                    err_d   = err_q | (m_rresp != RESP_OKAY);
                    if (beat_q == word_idx) begin
                        rdata_d = m_rdata;
                        rresp_d = m_rresp;
                    end
                    // An errored line keeps its tag but is never marked valid.
                    if (m_rlast) begin
                        meta_wr       = 1'b1;
                        meta_wr_valid = ~err_d;
                        state_d       = S_RESP;
                    end
                end
            end
            S_RESP: begin
                s_rvalid = 1'b1;
                if (s_rready) begin
                    state_d = S_IDLE;
                end
            end
            S_FLUSH: begin
                clear_all  = 1'b1;
                flush_done = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            rdata_q      <= '0;
            rresp_q      <= RESP_OKAY;
            beat_q       <= '0;
            err_q        <= 1'b0;
            flush_pend_q <= 1'b0;
            flush_req_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rdata_q      <= rdata_d;
            rresp_q      <= rresp_d;
            beat_q       <= beat_d;
            err_q        <= err_d;
            flush_pend_q <= flush_pend_d;
            flush_req_q  <= flush_req;
        end
    end

    assign s_rdata   = rdata_q;
    assign s_rresp   = rresp_q;
    assign m_araddr  = {addr_q[29:WORD_W], {(WORD_W + 2){1'b0}}};
    assign m_arlen   = 8'(LINE_WORDS - 1);
    assign m_arsize  = AXI_SIZE_4B;
    assign m_arburst = AXI_BURST_INCR;

`ifdef ICACHE_PERF_EN
    logic [31:0] perf_hit_q, perf_hit_d;
    logic [31:0] perf_miss_q, perf_miss_d;

    always_comb begin
        perf_hit_d  = perf_hit_q;
        perf_miss_d = perf_miss_q;
        if (state_q == S_LOOKUP) begin
            if (lookup_hit) begin
                perf_hit_d = perf_hit_q + 32'd1;
            end else begin
                perf_miss_d = perf_miss_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_hit_q  <= '0;
            perf_miss_q <= '0;
        end else begin
            perf_hit_q  <= perf_hit_d;
            perf_miss_q <= perf_miss_d;
        end
    end

    assign perf_hit  = perf_hit_q;
    assign perf_miss = perf_miss_q;
`else
    // Counters are not built; cache behaviour is unchanged.
`endif

endmodule

// File: tb/tb_ysyx_24100006_icache.sv
// Self-checking bench for ysyx_24100006_icache: AXI memory responder plus a line-level cache model.
module tb_ysyx_24100006_icache;

    localparam int NSETS = 16;
    localparam int LW    = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush_req = 1'b0;
    logic        flush_done;
    logic [31:0] s_araddr = '0;
    logic        s_arvalid = 1'b0;
    logic        s_arready;
    logic        s_rvalid;
    logic        s_rready = 1'b0;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic [31:0] m_araddr;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic        m_arvalid;
    logic        m_arready;
    logic        m_rvalid;
    logic        m_rready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rlast;
`ifdef ICACHE_PERF_EN
    logic [31:0] perf_hit;
    logic [31:0] perf_miss;
`endif

    int tests = 0;
    int fails = 0;
    int err_beat = -1;
    int cyc = 0;
    int rlast_cyc = 0;
    int burst_cnt = 0;
    logic [31:0] ar_addr_seen = '0;
    logic [7:0]  ar_len_seen = '0;
    logic [2:0]  ar_size_seen = '0;
    logic [1:0]  ar_burst_seen = '0;

    bit          ref_valid [NSETS];
    logic [31:0] ref_tag   [NSETS];

    ysyx_24100006_icache #(.NSETS(NSETS), .LINE_WORDS(LW)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush_req  (flush_req),
        .flush_done (flush_done),
        .s_araddr   (s_araddr),
        .s_arvalid  (s_arvalid),
        .s_arready  (s_arready),
        .s_rvalid   (s_rvalid),
        .s_rready   (s_rready),
        .s_rdata    (s_rdata),
        .s_rresp    (s_rresp),
        .m_araddr   (m_araddr),
        .m_arlen    (m_arlen),
        .m_arsize   (m_arsize),
        .m_arburst  (m_arburst),
        .m_arvalid  (m_arvalid),
        .m_arready  (m_arready),
        .m_rvalid   (m_rvalid),
        .m_rready   (m_rready),
        .m_rdata    (m_rdata),
        .m_rresp    (m_rresp),
        .m_rlast    (m_rlast)
`ifdef ICACHE_PERF_EN
        ,
        .perf_hit   (perf_hit),
        .perf_miss  (perf_miss)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    // Bus monitor: cycle count, burst requests and the cycle after each last beat.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (m_rvalid && m_rready && m_rlast) rlast_cyc <= cyc + 1;
        if (m_arvalid && m_arready) begin
            burst_cnt     <= burst_cnt + 1;
            ar_addr_seen  <= m_araddr;
            ar_len_seen   <= m_arlen;
            ar_size_seen  <= m_arsize;
            ar_burst_seen <= m_arburst;
        end
    end

    // Instruction memory: accepts a burst after a random delay, returns LW beats with random gaps.
    initial begin : axi_mem
        logic [31:0] base;
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        m_rdata   = '0;
        m_rresp   = 2'b00;
        m_rlast   = 1'b0;
        forever begin
            @(negedge clk);
            if (m_arvalid && !reset) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                base = m_araddr;
                m_arready = 1'b1;
                @(negedge clk);
                m_arready = 1'b0;
                for (int b = 0; b < LW; b++) begin
                    repeat ($urandom_range(0, 1)) @(negedge clk);
                    m_rvalid = 1'b1;
                    m_rdata  = mem_word(base + 32'(4 * b));
                    m_rresp  = (b == err_beat) ? 2'b10 : 2'b00;
                    m_rlast  = (b == LW - 1);
                    @(negedge clk);
                    m_rvalid = 1'b0;
                    m_rlast  = 1'b0;
                end
            end
        end
    end

    // Reference model: one entry per set, filled on miss, valid only for an error-free line.
    task automatic model_fetch(input logic [31:0] a, output bit hit,
                               output logic [31:0] data, output logic [1:0] resp);
        int s, w;
        logic [31:0] tg;
        s    = int'((a / (4 * LW)) % NSETS);
        w    = int'((a / 4) % LW);
        tg   = a / (4 * LW * NSETS);
        hit  = ref_valid[s] && (ref_tag[s] == tg);
        data = mem_word(a);
        resp = (!hit && err_beat == w) ? 2'b10 : 2'b00;
        if (!hit) begin
            ref_tag[s]   = tg;
            ref_valid[s] = (err_beat < 0);
        end
    endtask

    task automatic model_flush();
        for (int i = 0; i < NSETS; i++) ref_valid[i] = 1'b0;
    endtask

    // Drives one fetch and reports what was observed; callers decide what to expect.
    task automatic do_fetch(input logic [31:0] a, input int hold,
                            output logic [31:0] data, output logic [1:0] resp,
                            output int rv_k, output int ar_k, output int bursts,
                            output int rv_cyc, output bit stable);
        int n, b0;
        data = '0; resp = '0; rv_k = -1; ar_k = 0; rv_cyc = -1; stable = 1'b1;
        @(negedge clk);
        s_arvalid = 1'b1;
        s_araddr  = a;
        #1;
        n = 0;
        while (!s_arready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        b0 = burst_cnt;
        #1;
        s_arvalid = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (m_arvalid && ar_k == 0) ar_k = k;
            if (s_rvalid) begin
                rv_k = k;
                break;
            end
        end
        if (rv_k > 0) begin
            rv_cyc = cyc;
            data   = s_rdata;
            resp   = s_rresp;
            repeat (hold) begin
                @(negedge clk);
                if (!s_rvalid || s_rdata !== data || s_rresp !== resp) stable = 1'b0;
            end
            s_rready = 1'b1;
            @(negedge clk);
            s_rready = 1'b0;
            if (s_rvalid) stable = 1'b0;
        end
        bursts = burst_cnt - b0;
        $display("[TB] fetch %08h -> data %08h resp %0d lat %0d bursts %0d", a, data, resp, rv_k, bursts);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        tests++;
        if (s_arready !== 1'b1) begin
            fails++; $display("FAIL reset_arready got %b want 1", s_arready);
        end
        tests++;
        if ({s_rvalid, m_arvalid, m_rready, flush_done} !== 4'b0000) begin
            fails++; $display("FAIL reset_handshakes got %b want 0000", {s_rvalid, m_arvalid, m_rready, flush_done});
        end
        tests++;
        if (s_rdata !== 32'h0 || s_rresp !== 2'b00) begin
            fails++; $display("FAIL reset_rdata got %h/%b want 0/00", s_rdata, s_rresp);
        end
`ifdef ICACHE_PERF_EN
        tests++;
        if (perf_hit !== 32'h0 || perf_miss !== 32'h0) begin
            fails++; $display("FAIL reset_perf got %0d/%0d want 0/0", perf_hit, perf_miss);
        end
`endif
    endtask

    task automatic test_cold_miss();
        logic [31:0] d, ed; logic [1:0] r, er; bit h, st; int rk, ak, bs, rc;
        model_fetch(32'h30000000, h, ed, er);
        do_fetch(32'h30000000, 0, d, r, rk, ak, bs, rc, st);
        tests++;
        if (bs !== 1) begin fails++; $display("FAIL cold_bursts got %0d want 1", bs); end
        tests++;
        if (ar_addr_seen !== 32'h30000000 || ar_len_seen !== 8'd3) begin
            fails++; $display("FAIL cold_ar got %h/%0d want 30000000/3", ar_addr_seen, ar_len_seen);
        end
        tests++;
        if (ar_size_seen !== 3'b010 || ar_burst_seen !== 2'b01) begin
            fails++; $display("FAIL cold_ar_type got %b/%b want 010/01", ar_size_seen, ar_burst_seen);
        end
        tests++;
        if (d !== ed || r !== er) begin fails++; $display("FAIL cold_data got %h/%b want %h/%b", d, r, ed, er); end
        tests++;
        if (ak !== 2 || rc !== rlast_cyc) begin
            fails++; $display("FAIL cold_timing got ar@%0d rv@%0d want ar@2 rv@%0d", ak, rc, rlast_cyc);
        end
        model_fetch(32'h30000004, h, ed, er);
        do_fetch(32'h30000004, 0, d, r, rk, ak, bs, rc, st);
        tests++;
        if (bs !== 0 || rk !== 2) begin fails++; $display("FAIL hit_timing got bursts %0d lat %0d want 0/2", bs, rk); end
        tests++;
        if (d !== ed || r !== 2'b00) begin fails++; $display("FAIL hit_data got %h/%b want %h/00", d, r, ed); end
    endtask

    task automatic test_flush_idle();
        logic [31:0] d, ed; logic [1:0] r, er; bit h, st; int rk, ak, bs, rc, cnt;
        @(negedge clk);
        flush_req = 1'b1;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            cnt += int'(flush_done);
        end
        flush_req = 1'b0;
        model_flush();
        tests++;
        if (cnt !== 1) begin fails++; $display("FAIL flush_pulse got %0d cycles want 1", cnt); end
        model_fetch(32'h3000000C, h, ed, er);
        do_fetch(32'h3000000C, 0, d, r, rk, ak, bs, rc, st);
        tests++;
        if (bs !== 1 || ar_addr_seen !== 32'h30000000) begin
            fails++; $display("FAIL flush_refetch got bursts %0d addr %h want 1/30000000", bs, ar_addr_seen);
        end
        tests++;
        if (d !== ed || rc !== rlast_cyc) begin
            fails++; $display("FAIL word3 got %h rv@%0d want %h rv@%0d", d, rc, ed, rlast_cyc);
        end
    endtask

    task automatic test_flush_collision();
        int cnt;
        @(negedge clk);
        flush_req = 1'b1;
        s_arvalid = 1'b1;
        s_araddr  = 32'h30000000;
        #1;
        tests++;
        if (s_arready !== 1'b0) begin fails++; $display("FAIL collide_arready got %b want 0", s_arready); end
        @(negedge clk);
        cnt = int'(flush_done);
        s_arvalid = 1'b0;
        @(negedge clk);
        flush_req = 1'b0;
        model_flush();
        tests++;
        if (cnt !== 1 || s_arready !== 1'b1) begin
            fails++; $display("FAIL collide_flush got done %0d arready %b want 1/1", cnt, s_arready);
        end
    endtask

    task automatic test_conflict();
        logic [31:0] d, ed, a; logic [1:0] r, er; bit h, st; int rk, ak, bs, rc, miss0;
`ifdef ICACHE_PERF_EN
        miss0 = int'(perf_miss);
`else
        miss0 = 0;
`endif
        for (int i = 0; i < 4; i++) begin
            a = (i % 2 == 0) ? 32'h30000100 : 32'h30000000;
            model_fetch(a, h, ed, er);
            do_fetch(a, 0, d, r, rk, ak, bs, rc, st);
            tests++;
            if (bs !== (h ? 0 : 1) || d !== ed) begin
                fails++; $display("FAIL conflict_%0d got bursts %0d data %h want %0d/%h", i, bs, d, h ? 0 : 1, ed);
            end
        end
`ifdef ICACHE_PERF_EN
        tests++;
        if (int'(perf_miss) - miss0 !== 4) begin
            fails++; $display("FAIL perf_miss got +%0d want +4", int'(perf_miss) - miss0);
        end
`endif
    endtask

    task automatic test_resp_stall();
        logic [31:0] d, ed; logic [1:0] r, er; bit h, st; int rk, ak, bs, rc;
        for (int i = 0; i < 2; i++) begin
            model_fetch(32'h30000058, h, ed, er);
            do_fetch(32'h30000058, 5, d, r, rk, ak, bs, rc, st);
            tests++;
            if (st !== 1'b1 || d !== ed || r !== er) begin
                fails++; $display("FAIL stall_%0d got stable %b data %h want 1/%h", i, st, d, ed);
            end
        end
    endtask

    task automatic test_slverr();
        logic [31:0] d, ed; logic [1:0] r, er; bit h, st; int rk, ak, bs, rc;
        err_beat = 1;
        model_fetch(32'h30000064, h, ed, er);
        do_fetch(32'h30000064, 0, d, r, rk, ak, bs, rc, st);
        err_beat = -1;
        tests++;
        if (r !== er || d !== ed) begin fails++; $display("FAIL slverr_resp got %b/%h want %b/%h", r, d, er, ed); end
        model_fetch(32'h30000064, h, ed, er);
        do_fetch(32'h30000064, 0, d, r, rk, ak, bs, rc, st);
        tests++;
        if (bs !== (h ? 0 : 1) || r !== er) begin
            fails++; $display("FAIL slverr_refetch got bursts %0d resp %b want %0d/%b", bs, r, h ? 0 : 1, er);
        end
    endtask

    task automatic test_flush_during_refill();
        logic [31:0] d, ed, a; logic [1:0] r, er; bit h, st; int rk, ak, bs, rc, n, early, late, first;
        a = 32'h30000838;
        model_fetch(a, h, ed, er);
        @(negedge clk);
        s_arvalid = 1'b1;
        s_araddr  = a;
        @(posedge clk);
        #1;
        s_arvalid = 1'b0;
        n = 0;
        while (!m_rready && n < 100) begin @(negedge clk); n++; end
        flush_req = 1'b1;
        early = 0;
        n = 0;
        while (!s_rvalid && n < 100) begin @(negedge clk); early += int'(flush_done); n++; end
        d = s_rdata;
        repeat (3) begin @(negedge clk); early += int'(flush_done); end
        s_rready = 1'b1;
        @(negedge clk);
        s_rready = 1'b0;
        late = 0; first = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (flush_done && first == 0) first = k;
            late += int'(flush_done);
        end
        flush_req = 1'b0;
        model_flush();
        tests++;
        if (early !== 0 || late !== 1 || first !== 1) begin
            fails++; $display("FAIL refill_flush got early %0d late %0d at %0d want 0/1/1", early, late, first);
        end
        tests++;
        if (d !== ed) begin fails++; $display("FAIL refill_flush_data got %h want %h", d, ed); end
        model_fetch(a, h, ed, er);
        do_fetch(a, 0, d, r, rk, ak, bs, rc, st);
        tests++;
        if (bs !== (h ? 0 : 1) || d !== ed) begin
            fails++; $display("FAIL refill_flush_refetch got bursts %0d want %0d", bs, h ? 0 : 1);
        end
    endtask

    task automatic test_random();
        logic [31:0] d, ed, a; logic [1:0] r, er; bit h, st; int rk, ak, bs, rc;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                @(negedge clk);
                flush_req = 1'b1;
                repeat (3) @(negedge clk);
                flush_req = 1'b0;
                model_flush();
            end
            err_beat = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, LW - 1)) : -1;
            a = 32'h30000000 + ($urandom_range(0, 3) << 8) + ($urandom_range(0, 3) << 4)
                + ($urandom_range(0, 3) << 2);
            model_fetch(a, h, ed, er);
            do_fetch(a, $urandom_range(0, 2), d, r, rk, ak, bs, rc, st);
            tests++;
            if (d !== ed || r !== er || st !== 1'b1) begin
                fails++; $display("FAIL rand_%0d data got %h/%b want %h/%b", i, d, r, ed, er);
            end
            tests++;
            if (bs !== (h ? 0 : 1) || (h && rk !== 2) || (!h && (ak !== 2 || rc !== rlast_cyc))) begin
                fails++; $display("FAIL rand_%0d path got bursts %0d lat %0d ar %0d want hit=%0d", i, bs, rk, ak, h);
            end
        end
        err_beat = -1;
    endtask

    initial begin
        for (int i = 0; i < NSETS; i++) begin
            ref_valid[i] = 1'b0;
            ref_tag[i]   = '0;
        end
        test_reset();
        test_cold_miss();
        test_flush_idle();
        test_flush_collision();
        test_conflict();
        test_resp_stall();
        test_slverr();
        test_flush_during_refill();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout after %0d cycles", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ysyx_24100006_icache.md
# ysyx_24100006_icache

Direct-mapped instruction cache between the IFU's AXI-Lite read port and the instruction-memory AXI4 bus. It accepts one word fetch at a time on a slave read channel and answers hits from local arrays. It refills a missing line with one INCR burst on the master side. It also implements the `fence.i` flush handshake: `flush_req` in, `flush_done` out, where `flush_done` returns the IFU to idle.

## Interface
Parameters:
- `NSETS`, 16: number of lines; power of two ≥ 2.
- `LINE_WORDS`, 4: 32-bit words per line; power of two ≥ 2.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `flush_req` in 1: level request to invalidate all lines (`fence.i`).
- `flush_done` out 1: one-cycle pulse when invalidation completes.
- `s_araddr` in 32: fetch address (word aligned).
- `s_arvalid` in 1, `s_arready` out 1: slave read-address handshake.
- `s_rvalid` out 1, `s_rready` in 1: slave read-data handshake.
- `s_rdata` out 32: instruction word.
- `s_rresp` out 2: `00` OKAY, `10` SLVERR (forwarded).
- `m_araddr` out 32, `m_arlen` out 8, `m_arsize` out 3, `m_arburst` out 2: burst request.
- `m_arvalid` out 1, `m_arready` in 1: master read-address handshake.
- `m_rvalid` in 1, `m_rready` out 1: master read-data handshake.
- `m_rdata` in 32, `m_rresp` in 2, `m_rlast` in 1: master read-data channel.
- `perf_hit` out 32, `perf_miss` out 32: only present with `ICACHE_PERF_EN`.

## Operation
Address split:
- `[1:0]` byte offset, ignored.
- Next `log2(LINE_WORDS)` bits: word index.
- Next `log2(NSETS)` bits: set index.
- Remaining high bits: tag.

States: `IDLE`, `LOOKUP`, `REFILL_AR`, `REFILL_R`, `RESP`, `FLUSH`.
- `IDLE`:
  - `s_arready=1` unless a flush is pending.
  - A pending flush has priority and goes to `FLUSH`.
  - Otherwise a handshake latches the address and goes to `LOOKUP`.
- `LOOKUP`:
  - Compare `valid[set]` and `tag[set]`.
  - Hit: capture the word, set `s_rresp=00`, go to `RESP`.
  - Miss: go to `REFILL_AR`.
- `REFILL_AR`:
  - `m_arvalid=1`, `m_araddr` = line-aligned address, `m_arlen=LINE_WORDS-1`, `m_arsize=3'b010`, `m_arburst=2'b01`.
  - On `m_arready` go to `REFILL_R`.
- `REFILL_R`:
  - `m_rready=1`. A beat counter (0..`LINE_WORDS`-1) writes each beat into the data array.
  - The beat whose counter equals the requested word index is captured with its `m_rresp`.
  - Any non-OKAY beat sets a sticky error.
  - On `m_rlast`, write `tag[set]`. Set `valid[set]=1` only if there was no error. Go to `RESP`.
  - The response is returned only after the whole line, never early.
- `RESP`:
  - `s_rvalid=1`. `s_rdata` and `s_rresp` are held stable until `s_rready`, then go to `IDLE`.
- `FLUSH`:
  - Clear all valid bits in one cycle, pulse `flush_done`, go to `IDLE`.

Flush handling:
- A `flush_req` rising edge sets `flush_pend`. The pending flag is cleared when the flush is taken.
- A flush requested during a lookup, refill or response waits until that transaction has fully completed.
- A line being refilled when the flush arrives is still installed, then invalidated by the flush.

## Timing
- Reset values:
  - State `IDLE`, all valid bits 0, `flush_pend=0`.
  - All valid/ready outputs 0 except `s_arready=1`.
  - `flush_done=0`, `s_rdata=0`, `s_rresp=0`, perf counters 0.
- Hit: handshake in cycle N, `s_rvalid` in N+2.
- Miss: `m_arvalid` in N+2. `s_rvalid` one cycle after the `m_rlast` beat.
- Only one outstanding transaction; `s_arready=0` outside `IDLE`.
- `m_arvalid` is held until accepted; address/len are stable while it is high.
- Reset mid-refill returns to `IDLE` immediately. Draining the external burst is the system reset's responsibility.
- Simultaneous `flush_req` edge and `s_arvalid` in `IDLE`: the flush wins and `s_arready=0` that cycle.

## Configuration
`ICACHE_PERF_EN`:
- Defined:
  - `perf_hit` increments on each `LOOKUP` hit.
  - `perf_miss` increments on each `LOOKUP` miss.
  - Both are 32-bit wrapping counters, cleared only by reset.
- Undefined: the ports and counters are absent.
- Cache behaviour is identical either way.

## Structure
- Package `ysyx_24100006_icache_pkg`: state enum, `AXI_BURST_INCR`, `AXI_SIZE_4B`, `RESP_OKAY`/`RESP_SLVERR`, index/offset width functions.
- Sub-module `ysyx_24100006_icache_meta`: tag plus valid array with read port, write port, and single-cycle clear-all.
- Data array and FSM live in the top module.

## Test plan
- Cold fetch `0x30000000`:
  - Exactly one burst with `m_araddr=0x30000000`, `arlen=3`; `s_rdata` = beat 0.
  - A following `0x30000004` is a hit: `s_rvalid` 2 cycles after handshake, no `m_arvalid`.
- Fetch `0x3000000C` cold: `m_araddr=0x30000000`, `s_rdata` = beat 3, `s_rvalid` the cycle after `m_rlast`.
- Alternate `0x30000000` / `0x30000100` (same set): every access misses; `perf_miss=4` after 4 fetches (`ICACHE_PERF_EN`).
- Fill line, pulse `flush_req`: `flush_done` high exactly one cycle; next fetch of the same address misses. With `flush_req` raised during `REFILL_R`, `flush_done` follows only after `s_rready` completes.
- `s_rready` low for 5 cycles in `RESP`: `s_rvalid`, `s_rdata`, `s_rresp` stable throughout.
- Refill with beat 1 `m_rresp=2'b10`: `s_rresp=2'b10` delivered; the re-fetch misses again (line not validated).
